// File: rtl/seq_evt_pkg.sv
// Shared definitions for the windowed Z1/Z2 event counter:
// the controller state encoding and the default window/counter sizes.
package seq_evt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COUNT  = 2'b01,
        REPORT = 2'b10
    } state_t;

    localparam int DEF_WINDOW = 16;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/seq_event_counter_sat_counter.sv
// sat_counter: CNT_W-wide event counter with synchronous clear, +1 increment,
// saturation at all-ones and a sticky saturation flag.
// The next-state value is exported so the owner can capture a count that
// already includes the current sample.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] nxt_cnt_o,
    output logic             nxt_sat_o
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    // Next count: clear wins, otherwise add one unless already pinned at MAX
    always_comb begin
        nxt_cnt_o = cnt_q;
        nxt_sat_o = sat_q;
        if (clr_i) begin
            nxt_cnt_o = '0;
            nxt_sat_o = 1'b0;
        end else if (inc_i && (cnt_q != MAX)) begin
            nxt_cnt_o = cnt_q + CNT_W'(1);
            nxt_sat_o = sat_q | (nxt_cnt_o == MAX);
        end
    end

    // Count and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= nxt_cnt_o;
            sat_q <= nxt_sat_o;
        end
    end

endmodule

// File: rtl/seq_event_counter.sv
// seq_event_counter: counts Z1/Z2 events over a window of WINDOW samples
// after a start request and presents the result with a valid/ready handshake.
// Optional build macro SEQ_EVT_EDGE_EN: count only rising edges of Z1/Z2
// instead of every high sample.
module seq_event_counter
    import seq_evt_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Z1,
    input  logic             Z2,
    output logic [CNT_W-1:0] z1_count,
    output logic [CNT_W-1:0] z2_count,
    output logic             z1_sat,
    output logic             z2_sat,
    output logic             both_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int              CYC_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WINDOW - 1);

    state_t           state_q;
    logic [CYC_W-1:0] cyc_q;
    logic             both_q;

    logic             win_clr;
    logic             sample;
    logic             z1_inc;
    logic             z2_inc;
    logic [CNT_W-1:0] z1_nxt;
    logic [CNT_W-1:0] z2_nxt;
    logic             z1_sat_nxt;
    logic             z2_sat_nxt;

    assign win_clr = (state_q == IDLE) && start;
    assign sample  = (state_q == COUNT);

`ifdef SEQ_EVT_EDGE_EN
    logic z1_prev_q;
    logic z2_prev_q;

    // Previous-sample history, cleared at window start so a high first sample counts
    always_ff @(posedge clk) begin
        if (rst || win_clr) begin
            z1_prev_q <= 1'b0;
            z2_prev_q <= 1'b0;
        end else if (sample) begin
            z1_prev_q <= Z1;
            z2_prev_q <= Z2;
        end
    end

    assign z1_inc = sample && Z1 && !z1_prev_q;
    assign z2_inc = sample && Z2 && !z2_prev_q;
`else
    assign z1_inc = sample && Z1;
    assign z2_inc = sample && Z2;
`endif

    sat_counter #(.CNT_W(CNT_W)) u_z1_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (win_clr),
        .inc_i     (z1_inc),
        .nxt_cnt_o (z1_nxt),
        .nxt_sat_o (z1_sat_nxt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_z2_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (win_clr),
        .inc_i     (z2_inc),
        .nxt_cnt_o (z2_nxt),
        .nxt_sat_o (z2_sat_nxt)
    );

    // Window controller with registered report outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            both_q    <= 1'b0;
            z1_count  <= '0;
            z2_count  <= '0;
            z1_sat    <= 1'b0;
            z2_sat    <= 1'b0;
            both_err  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= COUNT;
                        cyc_q   <= '0;
                        both_q  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                COUNT: begin
                    both_q <= both_q | (Z1 & Z2);
                    cyc_q  <= cyc_q + CYC_W'(1);
                    // Last sample of the window: report values include it
                    if (cyc_q == LAST_CYC) begin
                        state_q   <= REPORT;
                        z1_count  <= z1_nxt;
                        z2_count  <= z2_nxt;
                        z1_sat    <= z1_sat_nxt;
                        z2_sat    <= z2_sat_nxt;
                        both_err  <= both_q | (Z1 & Z2);
                        out_valid <= 1'b1;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        z1_count  <= '0;
                        z2_count  <= '0;
                        z1_sat    <= 1'b0;
                        z2_sat    <= 1'b0;
                        both_err  <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_event_counter.sv
// Testbench for seq_event_counter: three instances (16/8, 10/2, 1/3 window/width)
// driven by directed and random windows, checked against a window-level model.
module tb_seq_event_counter;

`ifdef SEQ_EVT_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    localparam int NDUT = 3;
    localparam int WIN [NDUT] = '{16, 10, 1};
    localparam int CW  [NDUT] = '{8, 2, 3};

    logic clk = 1'b0;
    logic rst;
    logic Z1, Z2;
    logic [NDUT-1:0] start_v;
    logic [NDUT-1:0] rdy_v;
    logic [NDUT-1:0] ov, bsy, s1, s2, be;
    logic [7:0] c1 [NDUT];
    logic [7:0] c2 [NDUT];

    logic [7:0] a_c1, a_c2;
    logic [1:0] b_c1, b_c2;
    logic [2:0] x_c1, x_c2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_event_counter #(.WINDOW(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .Z1(Z1), .Z2(Z2),
        .z1_count(a_c1), .z2_count(a_c2), .z1_sat(s1[0]), .z2_sat(s2[0]),
        .both_err(be[0]), .out_valid(ov[0]), .out_ready(rdy_v[0]), .busy(bsy[0]));

    seq_event_counter #(.WINDOW(10), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .Z1(Z1), .Z2(Z2),
        .z1_count(b_c1), .z2_count(b_c2), .z1_sat(s1[1]), .z2_sat(s2[1]),
        .both_err(be[1]), .out_valid(ov[1]), .out_ready(rdy_v[1]), .busy(bsy[1]));

    seq_event_counter #(.WINDOW(1), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .Z1(Z1), .Z2(Z2),
        .z1_count(x_c1), .z2_count(x_c2), .z1_sat(s1[2]), .z2_sat(s2[2]),
        .both_err(be[2]), .out_valid(ov[2]), .out_ready(rdy_v[2]), .busy(bsy[2]));

    assign c1[0] = a_c1;
    assign c2[0] = a_c2;
    assign c1[1] = {6'b0, b_c1};
    assign c2[1] = {6'b0, b_c2};
    assign c1[2] = {5'b0, x_c1};
    assign c2[2] = {5'b0, x_c2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Window-level reference: count events in a list of samples, clip at the counter maximum
    function automatic void model(input int w, input int cw, input bit [15:0] a, input bit [15:0] b,
                                  output int e1, output int e2, output bit f1, output bit f2,
                                  output bit fb);
        int n1 = 0;
        int n2 = 0;
        int maxv = (1 << cw) - 1;
        fb = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (a[i] && (!EDGE_MODE || i == 0 || !a[i-1])) n1++;
            if (b[i] && (!EDGE_MODE || i == 0 || !b[i-1])) n2++;
            if (a[i] && b[i]) fb = 1'b1;
        end
        e1 = (n1 > maxv) ? maxv : n1;
        e2 = (n2 > maxv) ? maxv : n2;
        f1 = (n1 >= maxv);
        f2 = (n2 >= maxv);
    endfunction

    task automatic check_report(input int sel, input int e1, input int e2, input bit f1,
                                input bit f2, input bit fb, input string tag);
        chk({tag, ".valid"}, 32'(ov[sel]), 32'd1);
        chk({tag, ".z1_count"}, 32'(c1[sel]), 32'(e1));
        chk({tag, ".z2_count"}, 32'(c2[sel]), 32'(e2));
        chk({tag, ".z1_sat"}, 32'(s1[sel]), 32'(f1));
        chk({tag, ".z2_sat"}, 32'(s2[sel]), 32'(f2));
        chk({tag, ".both_err"}, 32'(be[sel]), 32'(fb));
        chk({tag, ".busy"}, 32'(bsy[sel]), 32'd1);
    endtask

    // One full window: start, WINDOW samples, hold cycles with ready low, handshake
    task automatic run_window(input int sel, input bit [15:0] a, input bit [15:0] b,
                              input int hold, input bit hs_start, input string tag);
        int e1, e2;
        bit f1, f2, fb;
        int w = WIN[sel];
        model(w, CW[sel], a, b, e1, e2, f1, f2, fb);
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        chk({tag, ".busy_after_start"}, 32'(bsy[sel]), 32'd1);
        chk({tag, ".valid_after_start"}, 32'(ov[sel]), 32'd0);
        for (int i = 0; i < w; i++) begin
            Z1 = a[i];
            Z2 = b[i];
            @(posedge clk); #1;
            if (i < w - 1) chk({tag, ".early_valid"}, 32'(ov[sel]), 32'd0);
        end
        Z1 = 1'b0;
        Z2 = 1'b0;
        check_report(sel, e1, e2, f1, f2, fb, tag);
        for (int h = 0; h < hold; h++) begin
            start_v[sel] = (h == hold / 2);
            @(posedge clk); #1;
            check_report(sel, e1, e2, f1, f2, fb, {tag, ".hold"});
        end
        start_v[sel] = hs_start;
        rdy_v[sel] = 1'b1;
        @(posedge clk); #1;
        rdy_v[sel] = 1'b0;
        start_v[sel] = 1'b0;
        chk({tag, ".valid_after_hs"}, 32'(ov[sel]), 32'd0);
        chk({tag, ".z1_after_hs"}, 32'(c1[sel]), 32'd0);
        chk({tag, ".z2_after_hs"}, 32'(c2[sel]), 32'd0);
        chk({tag, ".flags_after_hs"}, 32'({s1[sel], s2[sel], be[sel]}), 32'd0);
        chk({tag, ".busy_after_hs"}, 32'(bsy[sel]), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".idle_stays"}, 32'(bsy[sel]), 32'd0);
    endtask

    initial begin
        bit [15:0] ra, rb;
        rst = 1'b1;
        Z1 = 1'b0;
        Z2 = 1'b0;
        start_v = '0;
        rdy_v = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("reset.busy", 32'(bsy[d]), 32'd0);
            chk("reset.valid", 32'(ov[d]), 32'd0);
            chk("reset.counts", 32'({c1[d], c2[d]}), 32'd0);
            chk("reset.flags", 32'({s1[d], s2[d], be[d]}), 32'd0);
        end
        rst = 1'b0;
        // start held high during reset must not have launched a window
        start_v = '1;
        rst = 1'b1;
        @(posedge clk); #1;
        start_v = '0;
        rst = 1'b0;
        chk("reset_over_start.busy", 32'(bsy), 32'd0);

        // Three separate Z1 pulses, two Z2 pulses
        run_window(0, 16'b0000_0010_0010_0010, 16'b0001_0000_0000_1000, 0, 1'b0, "basic");
        // Z1 held high for four consecutive samples
        run_window(0, 16'b0000_0000_0011_1100, 16'h0000, 0, 1'b0, "held4");
        // Z1 and Z2 high together once
        run_window(0, 16'b0000_0000_1000_0000, 16'b0000_0000_1000_0000, 0, 1'b0, "both");
        // Ready held low ten cycles with a start pulse, start high in handshake cycle
        run_window(0, 16'hF00F, 16'h0F0F, 10, 1'b1, "hold10");
        // Narrow counter: five separate Z1 events saturate at 3
        run_window(1, 16'b0000_0001_0101_0101, 16'b0000_0000_0000_0010, 0, 1'b0, "sat2");
        // Single-sample window
        run_window(2, 16'h0001, 16'h0001, 2, 1'b0, "w1_both");
        run_window(2, 16'h0000, 16'h0001, 0, 1'b0, "w1_z2");

        // Reset on the 8th window cycle discards the window
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        Z1 = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        Z1 = 1'b0;
        chk("midreset.busy", 32'(bsy[0]), 32'd0);
        chk("midreset.valid", 32'(ov[0]), 32'd0);
        chk("midreset.counts", 32'({c1[0], c2[0]}), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("midreset.no_report", 32'({ov[0], bsy[0]}), 32'd0);
        end

        // Random windows on every instance
        for (int r = 0; r < 8; r++) begin
            for (int d = 0; d < NDUT; d++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (r[0]) rb = rb | ra;
                run_window(d, ra, rb, int'($urandom_range(0, 3)), 1'(r[1]), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_event_counter.md
SEQ_EVENT_COUNTER -- requirements
Module: seq_event_counter

Interface
REQ-001 Parameter WINDOW, 16, number of clock cycles in one counting window (>=1).
REQ-002 Parameter CNT_W, 8, width of each event counter.
REQ-003 Port clk input 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst input 1: reset, synchronous and active-high.
REQ-005 Port start input 1: window start request; honoured only in IDLE.
REQ-006 Port Z1 input 1: sequence-detector event 1, driven by the upstream Mealy FSM.
REQ-007 Port Z2 input 1: sequence-detector event 2, driven by the upstream Mealy FSM.
REQ-008 Port z1_count output CNT_W: Z1 events counted in the last completed window.
REQ-009 Port z2_count output CNT_W: Z2 events counted in the last completed window.
REQ-010 Port z1_sat output 1: z1_count saturated during the window.
REQ-011 Port z2_sat output 1: z2_count saturated during the window.
REQ-012 Port both_err output 1: Z1 and Z2 were sampled high together at least once in the window.
REQ-013 Port out_valid output 1: report outputs are valid.
REQ-014 Port out_ready input 1: consumer accepts the report.
REQ-015 Port busy output 1: high in COUNT and REPORT.

Function
REQ-016 FSM states: IDLE, COUNT, REPORT.
- IDLE->COUNT on start=1.
- COUNT->REPORT after WINDOW samples.
- REPORT->IDLE on out_valid&&out_ready.
REQ-017 Start sampled high at edge k in IDLE: clear counters, flags and cycle counter, so Z1/Z2 are sampled at edges k+1..k+WINDOW.
REQ-018 At edge k+WINDOW: include that sample, copy counts and flags to the report outputs, and assert out_valid; latency from start is exactly WINDOW cycles.
REQ-019 Counters increment by 1 per counted event and saturate at 2^CNT_W-1; the matching _sat flag sets and stays set for the window.
REQ-020 Z1=Z2=1 in one sample: both counters increment and both_err sets (sticky for the window).
REQ-021 Report outputs hold stable while out_valid=1 and out_ready=0; out_valid deasserts the cycle after the handshake.
REQ-022 start is ignored in COUNT and REPORT; start high in the handshake cycle is not honoured until the cycle after IDLE is entered.
REQ-023 Report outputs are zero whenever out_valid=0.
REQ-024 WINDOW=1 is legal: one sample, then REPORT.

Reset
REQ-025 rst=1 at any edge: state IDLE; all counters, flags, report outputs, out_valid and busy 0 after that edge; rst overrides start and the handshake.
REQ-026 A reset mid-COUNT or mid-REPORT discards the window; no partial report is produced.

Configuration
REQ-027 Macro SEQ_EVT_EDGE_EN is defined: count only rising edges of Z1/Z2 (each level held high counts once); the previous-sample registers clear at window start, so high at the first sample counts.
REQ-028 Macro SEQ_EVT_EDGE_EN is undefined: count every sampled cycle in which Z1/Z2 is high.

Structure
REQ-029 Package seq_evt_pkg holds the state typedef (IDLE=2'b00, COUNT=2'b01, REPORT=2'b10) and the default WINDOW/CNT_W constants.
REQ-030 Sub-module sat_counter (CNT_W-wide clear, increment, saturate, sat flag) is instantiated twice, for Z1 and Z2.

Verification
REQ-031 WINDOW=16, CNT_W=8, macro undefined, start; Z1 high 3 separate cycles, Z2 high 2 cycles -> out_valid at edge k+16; z1_count=3, z2_count=2, sat=0, both_err=0.
REQ-032 CNT_W=2, Z1 high 5 cycles in window -> z1_count=3, z1_sat=1.
REQ-033 Hold out_ready=0 for 10 cycles after out_valid; pulse start during that time -> outputs stable, start ignored; out_ready=1 -> IDLE next cycle, outputs 0.
REQ-034 rst=1 at 8th window cycle -> next cycle IDLE, busy=0, out_valid=0; no report follows.
REQ-035 Z1 held high for 4 consecutive samples -> z1_count=1 with SEQ_EVT_EDGE_EN, z1_count=4 without.
REQ-036 Z1=Z2=1 in one sample -> z1_count=1, z2_count=1, both_err=1.
